sa_compute_stream: RTL and testbench
====================================

Name: sa_compute_stream

Overview:
- Next-generation weight-stationary systolic compute array with built-in activation skew, output deskew, an addressed weight-load FSM, a valid pipeline and optional bias/psum accumulation.
- Upper levels no longer hand-skew activations or track latency. They present one aligned activation vector per cycle and receive one aligned psum vector per result.
- Sits between the activation/weight/psum buffers and the output accumulator.

Parameters:
- MUL_DATAWIDTH, 8, signed activation/weight width
- ADD_DATAWIDTH, 32, signed psum/accumulator width (must be ≥ 2*MUL_DATAWIDTH)
- NUM_ROWS, 4, PE rows (activation lanes, reduction depth)
- NUM_COLS, 4, PE columns (output lanes)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_w_valid  in  1  weight row beat valid
- o_w_ready  out  1  weight beat accepted when high
- i_weight  in  MUL_DATAWIDTH x NUM_COLS  one weight row
- i_reload  in  1  request to drain and re-enter weight load
- i_act_valid  in  1  activation vector valid
- o_act_ready  out  1  activation vector accepted when high
- i_act  in  MUL_DATAWIDTH x NUM_ROWS  aligned (unskewed) activation vector
- i_psum  in  ADD_DATAWIDTH x NUM_COLS  bias/partial sum, sampled with i_act
- i_acc  in  1  1: add i_psum; 0: start from zero; sampled with i_act
- o_valid  out  1  o_psum valid
- o_psum  out  ADD_DATAWIDTH x NUM_COLS  aligned result vector
- o_weights_loaded  out  1  full weight set resident
- o_busy  out  1  in-flight count nonzero

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all weight regs, skew/deskew/pipeline regs, in-flight count and row counter = 0.
  - o_valid=0, o_psum=0, o_weights_loaded=0, o_busy=0, o_w_ready=1, o_act_ready=0.
  - Reset mid-operation discards all in-flight vectors; no o_valid follows.
- All ready outputs are registered functions of state. No combinational valid->ready path.
- FSM states:
  - IDLE:
    - o_w_ready=1.
    - An accepted weight beat writes row 0, row_cnt=1, goes to LOAD.
    - If NUM_ROWS==1, goes directly to READY.
  - LOAD:
    - o_w_ready=1.
    - Beat k writes W[row_cnt][*]; row_cnt++.
    - The beat writing row NUM_ROWS-1 moves to READY and sets o_weights_loaded=1 the next cycle.
    - Gaps in i_w_valid are allowed.
  - READY:
    - o_act_ready=1, o_w_ready=0.
    - i_reload moves to DRAIN; i_reload in the same cycle as an accepted act is legal, and that act is kept.
  - DRAIN:
    - o_act_ready=0, o_w_ready=0, o_weights_loaded=0.
    - Moves to IDLE when in-flight count == 0; can be the cycle after entry if already empty.
  - i_reload outside READY is ignored. i_act_valid outside READY is ignored (not accepted).
- Weights are never modified while any vector is in flight. Each result uses exactly the weight set resident when its vector was accepted.
- Datapath:
  - Activation row r is delayed r cycles (skew), then moves one column per cycle.
  - Psum moves one row per cycle down each column.
  - Column c output is delayed (NUM_COLS-1-c) cycles (deskew) so all columns emerge together.
- Latency:
  - LAT = NUM_ROWS + NUM_COLS cycles, fixed.
  - A vector accepted at edge t gives o_valid=1 with its o_psum during cycle t+LAT.
  - Throughput is 1 vector/cycle. Bubbles on input appear as identical bubbles on o_valid.
  - No output backpressure.
- Arithmetic:
  - o_psum[c] = (i_acc ? i_psum[c] : 0) + Σ_r sext(i_act[r]) * sext(W[r][c]).
  - All operands are two's complement; products are sign-extended to ADD_DATAWIDTH.
  - Sums wrap modulo 2^ADD_DATAWIDTH, with no saturation.
- o_psum holds its last value when o_valid=0. It is not zeroed.
- In-flight counter: width $clog2(LAT+1); +1 on act accept, -1 on o_valid, both in the same cycle leaves it unchanged. o_busy = (count != 0).

Test Plan:
- Reset: hold rst 2 cycles → o_valid=0, o_psum all 0, o_w_ready=1, o_act_ready=0, o_weights_loaded=0.
- Load 4x4 identity (4 beats, one idle gap), act=[1,2,3,4], i_acc=0 accepted at t → o_weights_loaded=1, o_valid only at t+8, o_psum=[1,2,3,4].
- W all 8'hFF (-1), 4 back-to-back acts [127,127,127,127] then 1 bubble then 1 more → o_psum each column 32'hFFFFFE04 (-508); o_valid pattern 1,1,1,1,0,1 starting at t+8.
- Accumulate and wrap: i_acc=1, i_psum=[100,100,100,100], identity W, act=[1,2,3,4] → [101,102,103,104]. With ADD_DATAWIDTH=16: i_psum=32767, act/W giving 1 → 16'h8000.
- Reload during flight: accept 2 vectors, assert i_reload in the second accept cycle → o_act_ready=0 next cycle, o_w_ready stays 0 until the second o_valid, then IDLE. Old-weight results are correct; vectors after reloading new W use new W.
- Reset mid-compute: 3 vectors in flight, assert rst 1 cycle → no o_valid for 10 subsequent cycles, o_busy=0, o_weights_loaded=0, o_w_ready=1.

Source files
------------

// File: rtl/sa_compute_stream.sv
// Weight-stationary systolic array with internal activation skew, output deskew,
// an addressed weight-load FSM and a fixed-latency valid pipeline.
module sa_compute_stream #(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 32,
  parameter int NUM_ROWS      = 4,
  parameter int NUM_COLS      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_w_valid,
  output logic                               o_w_ready,
  input  logic [NUM_COLS*MUL_DATAWIDTH-1:0]  i_weight,
  input  logic                               i_reload,
  input  logic                               i_act_valid,
  output logic                               o_act_ready,
  input  logic [NUM_ROWS*MUL_DATAWIDTH-1:0]  i_act,
  input  logic [NUM_COLS*ADD_DATAWIDTH-1:0]  i_psum,
  input  logic                               i_acc,
  output logic                               o_valid,
  output logic [NUM_COLS*ADD_DATAWIDTH-1:0]  o_psum,
  output logic                               o_weights_loaded,
  output logic                               o_busy
);
  localparam int M     = MUL_DATAWIDTH;
  localparam int A     = ADD_DATAWIDTH;
  localparam int LAT   = NUM_ROWS + NUM_COLS;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam int RC_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, READY, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [RC_W-1:0]          row_cnt;
  logic [CNT_W-1:0]         inflight;
  logic [LAT-1:0]           vld_p;
  logic                     w_acc, act_acc;
  logic [RC_W-1:0]          wr_row;
  logic signed [M-1:0]      weight [NUM_ROWS][NUM_COLS];
  logic [NUM_ROWS*NUM_COLS*M-1:0] act_pe;
  logic [NUM_COLS*A-1:0]    aligned;

  function automatic logic signed [A-1:0] mac(input logic signed [A-1:0] acc,
                                               input logic signed [M-1:0] a,
                                               input logic signed [M-1:0] w);
    logic signed [2*M-1:0] prod;
    prod = (2*M)'(a) * (2*M)'(w);
    return acc + A'(prod);
  endfunction

  assign w_acc   = i_w_valid & o_w_ready;
  assign act_acc = i_act_valid & o_act_ready;
  assign wr_row  = (state == IDLE) ? '0 : row_cnt;
  assign o_busy  = (inflight != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (w_acc) state_nxt = (NUM_ROWS == 1) ? READY : LOAD;
      LOAD:    if (w_acc && row_cnt == RC_W'(NUM_ROWS - 1)) state_nxt = READY;
      READY:   if (i_reload) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready/loaded flags are registered from the next state, so no valid->ready path exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      row_cnt          <= '0;
      inflight         <= '0;
      o_w_ready        <= 1'b1;
      o_act_ready      <= 1'b0;
      o_weights_loaded <= 1'b0;
    end else begin
      state            <= state_nxt;
      o_w_ready        <= (state_nxt == IDLE) || (state_nxt == LOAD);
      o_act_ready      <= (state_nxt == READY);
      o_weights_loaded <= (state_nxt == READY);
      if (w_acc) row_cnt <= (state == IDLE) ? RC_W'(1) : row_cnt + 1'b1;
      case ({act_acc, vld_p[LAT-1]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Weights only change in IDLE/LOAD, which are unreachable while anything is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < NUM_COLS; c++) weight[r][c] <= '0;
    end else if (w_acc) begin
      for (int c = 0; c < NUM_COLS; c++) weight[wr_row][c] <= i_weight[c*M +: M];
    end
  end

  // p0: activation row r is held r cycles for skew, then steps one column per cycle.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic signed [M-1:0] act_p [r+NUM_COLS];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < r + NUM_COLS; k++) act_p[k] <= '0;
      end else begin
        act_p[0] <= i_act[r*M +: M];
        for (int k = 1; k < r + NUM_COLS; k++) act_p[k] <= act_p[k-1];
      end
    end
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_tap
      assign act_pe[(r*NUM_COLS+c)*M +: M] = act_p[r+c];
    end
  end

  // p1: bias skew, psum chain down the rows, then deskew so every column lands together.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic signed [A-1:0] bias_p [c+1];
    logic signed [A-1:0] ps_p   [NUM_ROWS];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= c; k++) bias_p[k] <= '0;
        for (int r = 0; r < NUM_ROWS; r++) ps_p[r] <= '0;
      end else begin
        bias_p[0] <= i_acc ? $signed(i_psum[c*A +: A]) : '0;
        for (int k = 1; k <= c; k++) bias_p[k] <= bias_p[k-1];
        ps_p[0] <= mac(bias_p[c], act_pe[c*M +: M], weight[0][c]);
        for (int r = 1; r < NUM_ROWS; r++)
          ps_p[r] <= mac(ps_p[r-1], act_pe[(r*NUM_COLS+c)*M +: M], weight[r][c]);
      end
    end
    if (c == NUM_COLS - 1) begin : g_nodsk
      assign aligned[c*A +: A] = ps_p[NUM_ROWS-1];
    end else begin : g_dsk
      logic signed [A-1:0] dsk_p [NUM_COLS-1-c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < NUM_COLS - 1 - c; k++) dsk_p[k] <= '0;
        end else begin
          dsk_p[0] <= ps_p[NUM_ROWS-1];
          for (int k = 1; k < NUM_COLS - 1 - c; k++) dsk_p[k] <= dsk_p[k-1];
        end
      end
      assign aligned[c*A +: A] = dsk_p[NUM_COLS-2-c];
    end
  end

  // p2: valid pipeline and output register; o_psum holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p   <= '0;
      o_valid <= 1'b0;
      o_psum  <= '0;
    end else begin
      vld_p   <= {vld_p[LAT-2:0], act_acc};
      o_valid <= vld_p[LAT-1];
      if (vld_p[LAT-1]) o_psum <= aligned;
    end
  end
endmodule

// File: tb/tb_sa_compute_stream.sv
// Directed + randomized bench for sa_compute_stream with a queue-based dot-product model.
module tb_sa_compute_stream;
  localparam int M = 8, A = 32, NR = 4, NC = 4, LAT = NR + NC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              i_w_valid = 1'b0, o_w_ready;
  logic [NC*M-1:0]   i_weight = '0;
  logic              i_reload = 1'b0;
  logic              i_act_valid = 1'b0, o_act_ready;
  logic [NR*M-1:0]   i_act = '0;
  logic [NC*A-1:0]   i_psum = '0;
  logic              i_acc = 1'b0;
  logic              o_valid;
  logic [NC*A-1:0]   o_psum;
  logic              o_weights_loaded, o_busy;

  sa_compute_stream #(.MUL_DATAWIDTH(M), .ADD_DATAWIDTH(A), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk(clk), .rst(rst), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_weight(i_weight),
    .i_reload(i_reload), .i_act_valid(i_act_valid), .o_act_ready(o_act_ready), .i_act(i_act),
    .i_psum(i_psum), .i_acc(i_acc), .o_valid(o_valid), .o_psum(o_psum),
    .o_weights_loaded(o_weights_loaded), .o_busy(o_busy));

  typedef struct { int due; logic [NC*A-1:0] res; } exp_t;
  exp_t expq[$];
  logic [M-1:0] mw [NR][NC];
  logic [M-1:0] ld [NR][NC];
  int mrow = 0, cyc = 0, checks = 0, failures = 0;

  // Expected column sums from the resident weights and the currently driven inputs.
  function automatic logic [NC*A-1:0] ref_out();
    logic [NC*A-1:0] v;
    longint s;
    for (int c = 0; c < NC; c++) begin
      s = i_acc ? longint'($signed(i_psum[c*A +: A])) : 64'sd0;
      for (int r = 0; r < NR; r++)
        s += longint'($signed(i_act[r*M +: M])) * longint'($signed(mw[r][c]));
      v[c*A +: A] = s[A-1:0];
    end
    return v;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic chk_v(input string tag, input logic [NC*A-1:0] obs, input logic [NC*A-1:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    bit   a_acc, w_acc, want_v;
    exp_t e;
    a_acc = i_act_valid && o_act_ready && !rst;
    w_acc = i_w_valid && o_w_ready && !rst;
    e.res = ref_out();
    @(posedge clk);
    cyc++;
    if (rst) begin
      expq.delete();
      mrow = 0;
    end else begin
      if (w_acc) begin
        for (int c = 0; c < NC; c++) mw[mrow][c] = i_weight[c*M +: M];
        mrow = (mrow + 1) % NR;
      end
      if (a_acc) begin
        e.due = cyc + LAT;
        expq.push_back(e);
      end
    end
    #1;
    want_v = (expq.size() > 0) && (expq[0].due == cyc);
    chk_b("o_valid", o_valid, want_v);
    if (want_v) begin
      chk_v("o_psum", o_psum, expq[0].res);
      expq.delete(0);
    end
  endtask

  task automatic load_mat(input bit gap);
    for (int r = 0; r < NR; r++) begin
      i_w_valid = 1'b1;
      for (int c = 0; c < NC; c++) i_weight[c*M +: M] = ld[r][c];
      step();
      if (gap && r == 1) begin
        i_w_valid = 1'b0;
        step();
      end
    end
    i_w_valid = 1'b0;
  endtask

  task automatic send(input logic [NR*M-1:0] a, input logic [NC*A-1:0] p, input bit acc);
    i_act_valid = 1'b1;
    i_act = a;
    i_psum = p;
    i_acc = acc;
    step();
    i_act_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_act_valid = 1'b0;
    i_reload = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) mw[r][c] = '0;

    // Reset
    repeat (2) step();
    chk_v("rst_psum", o_psum, '0);
    chk_b("rst_w_ready", o_w_ready, 1'b1);
    chk_b("rst_act_ready", o_act_ready, 1'b0);
    chk_b("rst_loaded", o_weights_loaded, 1'b0);
    chk_b("rst_busy", o_busy, 1'b0);
    rst = 1'b0;
    step();

    // Identity weights with a gap in the beats
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) ld[r][c] = (r == c) ? 8'd1 : 8'd0;
    load_mat(1'b1);
    chk_b("ident_loaded", o_weights_loaded, 1'b1);
    chk_b("ident_act_ready", o_act_ready, 1'b1);
    chk_b("ident_w_ready", o_w_ready, 1'b0);
    send({8'd4, 8'd3, 8'd2, 8'd1}, '0, 1'b0);
    idle(10);
    chk_v("ident_hold", o_psum, {32'd4, 32'd3, 32'd2, 32'd1});

    // Accumulate with bias, then wrap at the top of the signed range
    send({8'd4, 8'd3, 8'd2, 8'd1}, {4{32'd100}}, 1'b1);
    idle(10);
    chk_v("acc_bias", o_psum, {32'd104, 32'd103, 32'd102, 32'd101});
    send({8'd0, 8'd0, 8'd0, 8'd1}, {96'd0, 32'h7FFF_FFFF}, 1'b1);
    idle(10);
    chk_v("acc_wrap", o_psum, {96'd0, 32'h8000_0000});

    // Reload raised with the second of two accepted vectors
    send({8'd8, 8'd7, 8'd6, 8'd5}, {4{32'd3}}, 1'b1);
    i_act_valid = 1'b1;
    i_act = {8'hF0, 8'd9, 8'h80, 8'd127};
    i_acc = 1'b0;
    i_reload = 1'b1;
    step();
    i_reload = 1'b0;
    chk_b("drain_act_ready", o_act_ready, 1'b0);
    chk_b("drain_w_ready0", o_w_ready, 1'b0);
    chk_b("drain_loaded", o_weights_loaded, 1'b0);
    for (int k = 0; k < 20 && expq.size() > 0; k++) begin
      step();
      chk_b("drain_w_ready", o_w_ready, 1'b0);
    end
    i_act_valid = 1'b0;
    step();
    chk_b("drain_idle_w_ready", o_w_ready, 1'b1);
    chk_b("drain_idle_act_ready", o_act_ready, 1'b0);

    // All -1 weights, four back-to-back vectors, a bubble, one more
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) ld[r][c] = 8'hFF;
    load_mat(1'b0);
    chk_b("neg_loaded", o_weights_loaded, 1'b1);
    repeat (4) send({4{8'd127}}, '0, 1'b0);
    step();
    send({4{8'd127}}, '0, 1'b0);
    idle(10);
    chk_v("neg_sum", o_psum, {4{32'hFFFF_FE04}});

    // Reload with nothing in flight, then random weights and traffic
    i_reload = 1'b1;
    step();
    i_reload = 1'b0;
    step();
    chk_b("reload_empty_w_ready", o_w_ready, 1'b1);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) ld[r][c] = 8'($urandom());
    load_mat(1'($urandom_range(0, 1)));
    chk_b("rand_loaded", o_weights_loaded, 1'b1);
    repeat (150) begin
      i_act_valid = 1'($urandom_range(0, 1));
      i_w_valid = 1'($urandom_range(0, 1));
      i_weight = NC*M'($urandom());
      for (int r = 0; r < NR; r++) begin
        case ($urandom_range(0, 3))
          0: i_act[r*M +: M] = 8'h80;
          1: i_act[r*M +: M] = 8'h7F;
          default: i_act[r*M +: M] = 8'($urandom());
        endcase
      end
      for (int c = 0; c < NC; c++) i_psum[c*A +: A] = $urandom();
      i_acc = 1'($urandom_range(0, 1));
      step();
    end
    i_w_valid = 1'b0;
    idle(12);
    chk_b("rand_busy_done", o_busy, 1'b0);

    // Reset while three vectors are in flight
    repeat (3) send(NR*M'($urandom()), '0, 1'b0);
    chk_b("mid_busy", o_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(10);
    chk_b("mid_rst_busy", o_busy, 1'b0);
    chk_b("mid_rst_loaded", o_weights_loaded, 1'b0);
    chk_b("mid_rst_w_ready", o_w_ready, 1'b1);
    chk_b("mid_rst_act_ready", o_act_ready, 1'b0);
    chk_v("mid_rst_psum", o_psum, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
